// File: rtl/udma_uart_rx_deser.sv
// UART receive deserializer for the uDMA peripheral: oversampled start/data/parity/stop
// sampling, one-entry holding register with valid/ready handshake and error pulses.
module udma_uart_rx_deser (
  input  logic        periph_clk_i,
  input  logic        rst_i,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_parity_en_i,
  input  logic        cfg_stop_bits_i,
  input  logic        rx_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        rx_char_evt_o,
  output logic        err_overrun_o,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic        par_err;
  logic        second_stop;
  logic        sync1;
  logic        rxs;

  logic        stop_sample;
  logic        done;
  logic        frame_bad;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge periph_clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_i;
      rxs   <= sync1;
    end
  end

  // Completion is decoded in the stop-sample cycle so the holding register loads on that same edge.
  always_comb begin
    stop_sample = cfg_en_i && (state == STOP) && (cnt == 16'd0);
    done        = stop_sample && rxs && (second_stop || !cfg_stop_bits_i);
    frame_bad   = stop_sample && !rxs;
  end

  always_ff @(posedge periph_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      busy_o      <= 1'b0;
      cnt         <= 16'd0;
      bit_idx     <= 3'd0;
      shift       <= 8'd0;
      par_err     <= 1'b0;
      second_stop <= 1'b0;
    end else if (!cfg_en_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      cnt    <= 16'd0;
    end else if (state == IDLE) begin
      if (!rxs) begin
        state  <= START;
        busy_o <= 1'b1;
        cnt    <= cfg_div_i >> 1;
      end
    end else if (cnt != 16'd0) begin
      cnt <= cnt - 16'd1;
    end else begin
      cnt <= cfg_div_i;
      case (state)
        START: begin
          if (rxs) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            state   <= DATA;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            par_err <= 1'b0;
          end
        end
        DATA: begin
          shift[bit_idx] <= rxs;
          // Last data index is cfg_bits_i+4, i.e. 4..7 for 5..8 bits.
          if (bit_idx == {1'b1, cfg_bits_i}) begin
            state       <= cfg_parity_en_i ? PARITY : STOP;
            second_stop <= 1'b0;
          end else begin
            bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: begin
          par_err     <= rxs ^ (^shift);
          state       <= STOP;
          second_stop <= 1'b0;
        end
        STOP: begin
          if (!rxs || !cfg_stop_bits_i || second_stop) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            second_stop <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // A completed character is dropped only when the previous one is still held and not being taken.
  always_ff @(posedge periph_clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o        <= 8'd0;
      valid_o       <= 1'b0;
      rx_char_evt_o <= 1'b0;
      err_overrun_o <= 1'b0;
      err_parity_o  <= 1'b0;
      err_frame_o   <= 1'b0;
    end else begin
      rx_char_evt_o <= 1'b0;
      err_overrun_o <= 1'b0;
      err_parity_o  <= 1'b0;
      err_frame_o   <= frame_bad;
      if (done) begin
        if (valid_o && !ready_i) begin
          err_overrun_o <= 1'b1;
        end else begin
          data_o        <= shift;
          valid_o       <= 1'b1;
          rx_char_evt_o <= 1'b1;
          err_parity_o  <= par_err;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_udma_uart_rx_deser.sv
// Self-checking bench for udma_uart_rx_deser: directed frames plus randomized frames
// checked against a frame-level model of the holding register and error rules.
module tb_udma_uart_rx_deser;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cfg_en_i;
  logic [15:0] cfg_div_i;
  logic [1:0]  cfg_bits_i;
  logic        cfg_parity_en_i;
  logic        cfg_stop_bits_i;
  logic        rx_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        rx_char_evt_o;
  logic        err_overrun_o;
  logic        err_parity_o;
  logic        err_frame_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_evt, n_perr, n_ferr, n_ovr;
  int t_evt, t_start;
  logic [7:0] got_data;
  logic [7:0] prev_data;
  bit prev_hold = 1'b0;
  bit m_valid = 1'b0;
  logic [7:0] m_data = 8'd0;

  udma_uart_rx_deser dut (
    .periph_clk_i    (clk),
    .rst_i           (rst_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_div_i       (cfg_div_i),
    .cfg_bits_i      (cfg_bits_i),
    .cfg_parity_en_i (cfg_parity_en_i),
    .cfg_stop_bits_i (cfg_stop_bits_i),
    .rx_i            (rx_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .rx_char_evt_o   (rx_char_evt_o),
    .err_overrun_o   (err_overrun_o),
    .err_parity_o    (err_parity_o),
    .err_frame_o     (err_frame_o),
    .busy_o          (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters and held-data stability are observed mid-cycle.
  always @(negedge clk) begin
    if (rx_char_evt_o) begin
      n_evt++;
      got_data = data_o;
      t_evt = cyc;
    end
    if (err_parity_o)  n_perr++;
    if (err_frame_o)   n_ferr++;
    if (err_overrun_o) n_ovr++;
    if (prev_hold && !rst_i) checkOutput("hold_stable", {24'd0, data_o}, {24'd0, prev_data});
    prev_hold = valid_o && !ready_i && !rst_i;
    prev_data = data_o;
  end

  task automatic clear_counts();
    n_evt = 0; n_perr = 0; n_ferr = 0; n_ovr = 0; t_evt = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int len);
    rx_i = b;
    idle(len);
  endtask

  task automatic set_cfg(input int div, input int bits, input bit par, input bit stp);
    cfg_div_i = div[15:0];
    cfg_bits_i = bits[1:0];
    cfg_parity_en_i = par;
    cfg_stop_bits_i = stp;
    idle(2);
  endtask

  task automatic set_ready(input bit r);
    ready_i = r;
    idle(2);
    if (r) m_valid = 1'b0;
  endtask

  // Drives one frame (bad_stop: 0 none, 1 first stop low, 2 second stop low) then idles the line.
  task automatic applyStimulus(input logic [7:0] d, input bit flip, input int bad_stop, input int extra);
    int p = int'(cfg_div_i) + 1;
    int nb = int'(cfg_bits_i) + 5;
    int ns = cfg_stop_bits_i ? 2 : 1;
    logic [7:0] mask = 8'hFF >> (8 - nb);
    @(posedge clk); #1;
    t_start = cyc;
    drive_bit(1'b0, p + extra);
    for (int k = 0; k < nb; k++) drive_bit(d[k], p);
    if (cfg_parity_en_i) drive_bit((^(d & mask)) ^ flip, p);
    for (int s = 1; s <= ns; s++) drive_bit((bad_stop == s) ? 1'b0 : 1'b1, p);
    rx_i = 1'b1;
    idle(2 * p + 8);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input bit flip, input int bad_stop, input int extra);
    int p = int'(cfg_div_i) + 1;
    int nb = int'(cfg_bits_i) + 5;
    int ns = cfg_stop_bits_i ? 2 : 1;
    int par = cfg_parity_en_i ? 1 : 0;
    logic [7:0] dd = d & (8'hFF >> (8 - nb));
    bit sbad = (bad_stop != 0) && (bad_stop <= ns);
    int e_evt = 0, e_perr = 0, e_ovr = 0;
    int lat = 3 + int'(cfg_div_i >> 1) + (nb + par + ns) * p + 1;
    clear_counts();
    applyStimulus(d, flip, bad_stop, extra);
    if (!sbad) begin
      if (m_valid && !ready_i) e_ovr = 1;
      else begin
        e_evt = 1;
        e_perr = flip ? 1 : 0;
        m_data = dd;
        m_valid = 1'b1;
      end
    end
    if (ready_i) m_valid = 1'b0;
    checkOutput({tag, "_evt"}, n_evt, e_evt);
    checkOutput({tag, "_perr"}, n_perr, e_perr);
    checkOutput({tag, "_ferr"}, n_ferr, sbad ? 1 : 0);
    checkOutput({tag, "_ovr"}, n_ovr, e_ovr);
    if (e_evt == 1) begin
      checkOutput({tag, "_data"}, {24'd0, got_data}, {24'd0, dd});
      checkOutput({tag, "_latency"}, t_evt - t_start, lat);
    end
    checkOutput({tag, "_valid"}, {31'd0, valid_o}, {31'd0, m_valid});
    if (m_valid) checkOutput({tag, "_held"}, {24'd0, data_o}, {24'd0, m_data});
    checkOutput({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_data"}, {24'd0, data_o}, 32'd0);
    checkOutput({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
    checkOutput({tag, "_pulses"}, {28'd0, rx_char_evt_o, err_overrun_o, err_parity_o, err_frame_o}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; cfg_en_i = 1'b1; cfg_div_i = 16'd15; cfg_bits_i = 2'b11;
    cfg_parity_en_i = 1'b0; cfg_stop_bits_i = 1'b0; rx_i = 1'b1; ready_i = 1'b1;
    clear_counts();
    idle(3);
    check_reset_values("reset");
    rst_i = 1'b0;
    idle(3);

    // 8N1 at div=15
    set_cfg(15, 3, 1'b0, 1'b0);
    run_frame("8n1_a5", 8'hA5, 1'b0, 0, 0);

    // 7E2, good then flipped parity
    set_cfg(15, 2, 1'b1, 1'b1);
    run_frame("7e2_good", 8'h3C, 1'b0, 0, 0);
    run_frame("7e2_bad", 8'h3C, 1'b1, 0, 0);

    // Framing error then recovery
    set_cfg(15, 3, 1'b0, 1'b0);
    run_frame("frame_err", 8'hF0, 1'b0, 1, 0);
    run_frame("after_ferr", 8'h55, 1'b0, 0, 0);

    // Overrun with ready low
    set_ready(1'b0);
    run_frame("ovr_first", 8'h11, 1'b0, 0, 0);
    run_frame("ovr_second", 8'h22, 1'b0, 0, 0);
    set_ready(1'b1);
    checkOutput("ovr_release_valid", {31'd0, valid_o}, 32'd0);

    // Start-bit glitch of 4 cycles
    clear_counts();
    drive_bit(1'b0, 4);
    rx_i = 1'b1;
    idle(40);
    checkOutput("glitch_evt", n_evt + n_perr + n_ferr + n_ovr, 0);
    checkOutput("glitch_busy", {31'd0, busy_o}, 32'd0);

    // One-cycle bit period, start bit stretched so its sample lands inside it
    set_cfg(0, 3, 1'b0, 1'b0);
    run_frame("div0", 8'h96, 1'b0, 0, 1);

    // Randomized frames
    for (int i = 0; i < 24; i++) begin
      int r;
      int bad;
      bit stp;
      bit par;
      stp = 1'($urandom_range(0, 1));
      par = 1'($urandom_range(0, 1));
      set_cfg($urandom_range(1, 12), $urandom_range(0, 3), par, stp);
      set_ready(1'($urandom_range(0, 1)));
      r = $urandom_range(0, 7);
      bad = (r == 7) ? 1 : ((r == 6 && stp) ? 2 : 0);
      run_frame("rand", 8'($urandom), par ? 1'($urandom_range(0, 1)) : 1'b0, bad, 0);
    end

    // Enable dropped mid-frame
    set_cfg(15, 3, 1'b0, 1'b0);
    set_ready(1'b1);
    clear_counts();
    fork
      applyStimulus(8'hC3, 1'b0, 0, 0);
      begin
        idle(60);
        cfg_en_i = 1'b0;
      end
    join
    checkOutput("en_drop_out", n_evt + n_perr + n_ferr + n_ovr, 0);
    checkOutput("en_drop_busy", {31'd0, busy_o}, 32'd0);
    cfg_en_i = 1'b1;
    idle(2);
    run_frame("after_en", 8'h69, 1'b0, 0, 0);

    // Reset mid-frame with a held character
    set_ready(1'b0);
    run_frame("pre_rst", 8'h5A, 1'b0, 0, 0);
    clear_counts();
    fork
      applyStimulus(8'h81, 1'b0, 0, 0);
      begin
        idle(70);
        rst_i = 1'b1;
        #1;
        check_reset_values("mid_rst");
      end
    join
    rst_i = 1'b0;
    m_valid = 1'b0;
    m_data = 8'd0;
    idle(2);
    checkOutput("rst_out", n_evt + n_perr + n_ferr + n_ovr, 0);
    check_reset_values("post_rst");
    set_ready(1'b1);
    run_frame("after_rst", 8'hE7, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
